// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: lights one hole per round, scores hits and counts rounds.
// All outputs are registered. A prescaler tick paces the SHOW and GAP windows.
module mole_round_ctrl #(
  parameter int DIV        = 200,
  parameter int SHOW_TICKS = 50000,
  parameter int GAP_TICKS  = 25000,
  parameter int ROUNDS     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] key,
  output logic [7:0] mole,
  output logic [7:0] score,
  output logic [7:0] round_cnt,
  output logic       busy,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       done
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]   SHOW_LAST  = 16'(SHOW_TICKS - 1);
  localparam logic [15:0]   GAP_LAST   = 16'(GAP_TICKS - 1);
  localparam logic [7:0]    ROUNDS_L   = 8'(ROUNDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [2:0]    hole_q, hole_d;
  logic [7:0]    mole_q, mole_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    round_q, round_d;
  logic          busy_q, busy_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          done_q, done_d;

  logic          tick;
  logic          timer_run;
  logic [7:0]    round_inc;

  assign tick      = (presc_q == PRESC_LAST);
  assign round_inc = round_q + 8'd1;

  always_comb begin
    state_d = state_q;
    hole_d  = hole_q;
    score_d = score_q;
    round_d = round_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          score_d = 8'd0;
          round_d = 8'd0;
          hole_d  = lfsr_q[2:0];
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        // A hit in the timeout cycle still counts as a hit.
        if ((key & mole_q) != 8'd0) begin
          hit_d   = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          state_d = S_GAP;
        end else if (tick && tick_cnt_q == SHOW_LAST) begin
          miss_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick && tick_cnt_q == GAP_LAST) begin
          round_d = round_inc;
          if (round_inc == ROUNDS_L) begin
            state_d = S_DONE;
          end else begin
            hole_d  = lfsr_q[2:0];
            state_d = S_SHOW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timebase restarts from zero on every state entry and stays parked outside SHOW/GAP.
    timer_run = (state_q == S_SHOW || state_q == S_GAP) && (state_d == state_q);
    if (!timer_run) begin
      presc_d    = '0;
      tick_cnt_d = 16'd0;
    end else begin
      presc_d    = tick ? '0 : presc_q + PW'(1);
      tick_cnt_d = tick ? tick_cnt_q + 16'd1 : tick_cnt_q;
    end

    mole_d = (state_d == S_SHOW) ? (8'b1 << hole_d) : 8'd0;
    busy_d = (state_d == S_SHOW) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      tick_cnt_q <= 16'd0;
      lfsr_q     <= 8'hA5;
      hole_q     <= 3'd0;
      mole_q     <= 8'd0;
      score_q    <= 8'd0;
      round_q    <= 8'd0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      hole_q     <= hole_d;
      mole_q     <= mole_d;
      score_q    <= score_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      done_q     <= done_d;
    end
  end

  assign mole       = mole_q;
  assign score      = score_q;
  assign round_cnt  = round_q;
  assign busy       = busy_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: scenario tasks driving randomized keys against a round-level model.
module tb_mole_round_ctrl;

  localparam int ROUNDS   = 2;
  localparam int SHOW_CYC = 12;  // SHOW_TICKS * DIV
  localparam int GAP_CYC  = 8;   // GAP_TICKS * DIV

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] key = 8'd0;
  logic [7:0] mole, score, round_cnt;
  logic       busy, hit_pulse, miss_pulse, done;

  logic       start2 = 1'b0;
  logic [7:0] key2 = 8'd0;
  logic [7:0] mole2, score2, round2;
  logic       busy2, hit2, miss2, done2;

  int checks = 0;
  int errors = 0;
  int exp_score, exp_round;
  logic [2:0] exp_hole;
  logic [7:0] m_lfsr;

  mole_round_ctrl #(.DIV(4), .SHOW_TICKS(3), .GAP_TICKS(2), .ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .mole(mole), .score(score),
    .round_cnt(round_cnt), .busy(busy), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .done(done)
  );

  mole_round_ctrl #(.DIV(2), .SHOW_TICKS(1), .GAP_TICKS(1), .ROUNDS(255)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .key(key2), .mole(mole2), .score(score2),
    .round_cnt(round2), .busy(busy2), .hit_pulse(hit2), .miss_pulse(miss2), .done(done2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference random source: the documented LFSR, advanced once per clock since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start     = 1'b1;
    exp_hole  = m_lfsr[2:0];
    exp_score = 0;
    exp_round = 0;
    step();
    start = 1'b0;
  endtask

  // Plays one round from the first SHOW cycle. hit_at/wrong_at: SHOW cycle (1..12) of a
  // matching / non-matching key, anything else means none. poke drives start throughout.
  task automatic play_round(input int hit_at, input int wrong_at, input bit poke);
    logic [7:0] m;
    logic [7:0] wk;
    bit hit;
    hit = 1'b0;
    m = 8'b1 << exp_hole;
    for (int k = 1; k <= SHOW_CYC; k++) begin
      checks++;
      if (mole !== m || busy !== 1'b1 || round_cnt !== 8'(exp_round)) begin
        errors++;
        $display("FAIL show_state k=%0d: mole=%h busy=%b rounds=%0d, want mole=%h busy=1 rounds=%0d",
                 k, mole, busy, round_cnt, m, exp_round);
      end
      if (k == wrong_at) begin
        wk = 8'($urandom) & ~m;
        key = (wk == 8'd0) ? ~m : wk;
      end
      if (k == hit_at) key = m | 8'($urandom);
      start = poke;
      step();
      key = 8'd0;
      start = 1'b0;
      if (k == hit_at) begin
        hit = 1'b1;
        break;
      end
    end
    if (hit) exp_score = (exp_score == 255) ? 255 : exp_score + 1;
    checks++;
    if (hit_pulse !== hit || miss_pulse !== !hit || mole !== 8'd0 || score !== 8'(exp_score)) begin
      errors++;
      $display("FAIL round_result: hit=%b miss=%b mole=%h score=%0d, want hit=%b miss=%b mole=00 score=%0d",
               hit_pulse, miss_pulse, mole, score, hit, !hit, exp_score);
    end
    for (int g = 1; g <= GAP_CYC; g++) begin
      checks++;
      if (mole !== 8'd0 || busy !== 1'b1 || done !== 1'b0 ||
          (g > 1 && (hit_pulse !== 1'b0 || miss_pulse !== 1'b0))) begin
        errors++;
        $display("FAIL gap_state g=%0d: mole=%h busy=%b hit=%b miss=%b done=%b",
                 g, mole, busy, hit_pulse, miss_pulse, done);
      end
      key = 8'($urandom);
      start = poke;
      if (g == GAP_CYC) exp_hole = m_lfsr[2:0];
      step();
      key = 8'd0;
      start = 1'b0;
    end
    exp_round++;
    checks++;
    if (round_cnt !== 8'(exp_round) || score !== 8'(exp_score)) begin
      errors++;
      $display("FAIL gap_exit: rounds=%0d score=%0d, want rounds=%0d score=%0d",
               round_cnt, score, exp_round, exp_score);
    end
    if (exp_round == ROUNDS) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || mole !== 8'd0) begin
        errors++;
        $display("FAIL done_strobe: done=%b busy=%b mole=%h, want 1 0 00", done, busy, mole);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || mole !== 8'd0 ||
          score !== 8'(exp_score) || round_cnt !== 8'(ROUNDS)) begin
        errors++;
        $display("FAIL idle_after_done: done=%b busy=%b mole=%h score=%0d rounds=%0d, want 0 0 00 %0d %0d",
                 done, busy, mole, score, round_cnt, exp_score, ROUNDS);
      end
    end else begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL early_done: done=%b, want 0", done);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (mole !== 8'd0 || busy !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL %s: mole=%h busy=%b hit=%b miss=%b done=%b, want all 0",
               tag, mole, busy, hit_pulse, miss_pulse, done);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (score !== 8'd0 || round_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: score=%0d rounds=%0d, want 0 0", score, round_cnt);
    end
    check_idle("reset_outputs");
    #22 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_idle("idle_no_start");
  endtask

  task automatic test_no_key_game();
    do_start();
    play_round(0, 0, 1'b0);
    play_round(0, 0, 1'b0);
  endtask

  task automatic test_hit();
    do_start();
    play_round(5, 0, 1'b0);
    play_round(0, 0, 1'b0);
  endtask

  task automatic test_wrong_and_simul();
    do_start();
    play_round(SHOW_CYC, 3, 1'b0);
    play_round(0, 7, 1'b0);
  endtask

  task automatic test_start_ignored();
    do_start();
    play_round(2, 0, 1'b1);
    play_round(9, 0, 1'b1);
    do_start();
    checks++;
    if (score !== 8'd0 || round_cnt !== 8'd0) begin
      errors++;
      $display("FAIL restart_clear: score=%0d rounds=%0d, want 0 0", score, round_cnt);
    end
    play_round(4, 0, 1'b0);
    play_round(0, 0, 1'b0);
  endtask

  task automatic test_random_games();
    for (int gm = 0; gm < 6; gm++) begin
      repeat ($urandom_range(0, 5)) step();
      do_start();
      for (int r = 0; r < ROUNDS; r++)
        play_round(int'($urandom_range(0, 15)), int'($urandom_range(1, 12)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_show();
    logic [7:0] v;
    do_start();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    checks++;
    if (score !== 8'd0 || round_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_counts: score=%0d rounds=%0d, want 0 0", score, round_cnt);
    end
    step();
    rst_n = 1'b1;
    v = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      step();
      v = lfsr_next(v);
    end
    check_idle("post_reset_idle");
    start = 1'b1;
    exp_hole = v[2:0];
    exp_score = 0;
    exp_round = 0;
    step();
    start = 1'b0;
    play_round(0, 0, 1'b0);
    play_round(6, 0, 1'b0);
  endtask

  task automatic test_saturation();
    int hits, misses;
    bit seen;
    hits = 0;
    misses = 0;
    seen = 1'b0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    key2 = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      if (hit2) hits++;
      if (miss2) misses++;
      if (done2) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    key2 = 8'd0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sat_timeout: done never seen within 3000 cycles");
    end
    checks++;
    if (hits != 255 || misses != 0 || score2 !== 8'd255 || round2 !== 8'd255) begin
      errors++;
      $display("FAIL sat_score: hits=%0d misses=%0d score=%0d rounds=%0d, want 255 0 255 255",
               hits, misses, score2, round2);
    end
    step();
    checks++;
    if (score2 !== 8'd255 || busy2 !== 1'b0 || mole2 !== 8'd0) begin
      errors++;
      $display("FAIL sat_hold: score=%0d busy=%b mole=%h, want 255 0 00", score2, busy2, mole2);
    end
  endtask

  initial begin
    test_reset();
    test_no_key_game();
    test_hit();
    test_wrong_and_simul();
    test_start_ignored();
    test_random_games();
    test_reset_mid_show();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
